// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: grants one AXI-Stream requester at a time,
// holds the grant until its tlast beat transfers, then rotates priority.
module axis_rr_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 2
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [N_PORTS-1:0]          en_i,
  input  logic [N_PORTS-1:0]          tvalid_i,
  output logic [N_PORTS-1:0]          tready_o,
  input  logic [N_PORTS*DATA_W-1:0]   tdata_i,
  input  logic [N_PORTS-1:0]          tlast_i,
  output logic                        tvalid_o,
  input  logic                        tready_i,
  output logic [DATA_W-1:0]           tdata_o,
  output logic                        tlast_o,
  output logic [ID_W-1:0]             tid_o,
  output logic                        busy_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [N_PORTS-1:0] req;
  logic               hi_found, lo_found;
  logic [ID_W-1:0]    hi_sel, lo_sel;

  assign req = tvalid_i & en_i;

  // Rotating search split in two: lowest requester above ptr wins, otherwise
  // wrap around to the lowest requester at or below ptr.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (req[k]) begin
        if (k > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_sel   = ID_W'(k);
        end else begin
          lo_found = 1'b1;
          lo_sel   = ID_W'(k);
        end
      end
    end
  end

  always_comb begin
    tready_o = '0;
    tvalid_o = 1'b0;
    tdata_o  = '0;
    tlast_o  = 1'b0;
    tid_o    = '0;
    busy_o   = 1'b0;
    if (state_q == S_LOCK) begin
      busy_o = 1'b1;
      tid_o  = gnt_q;
      for (int k = 0; k < N_PORTS; k++) begin
        if (int'(gnt_q) == k) begin
          tvalid_o    = tvalid_i[k];
          tdata_o     = tdata_i[k*DATA_W +: DATA_W];
          tlast_o     = tlast_i[k];
          tready_o[k] = tready_i;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    if (state_q == S_IDLE) begin
      if (hi_found || lo_found) begin
        gnt_d   = hi_found ? hi_sel : lo_sel;
        state_d = S_LOCK;
      end
    end else if (tvalid_o && tready_i && tlast_o) begin
      ptr_d   = gnt_q;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= ID_W'(N_PORTS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one downstream AXI-Stream register buffer (`BUFFER`, 4-bit data) among N upstream requesters. It grants one requester at a time, holds the grant until that requester's `tlast` beat completes, then rotates priority. It sits directly in front of `BUFFER` and drives that buffer's slave side. The downstream handshake passes through combinationally while a grant is held.

## Interface
- `N_PORTS`, 4: number of requesters, 2..8.
- `DATA_W`, 4: data width per stream.
- `ID_W`, 2: width of `tid_o`; must satisfy 2^ID_W >= N_PORTS.

- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `arstn_i`  in  1  reset, synchronous and active-low.
- `en_i`  in  N_PORTS  per-requester enable mask; a 0 bit excludes that port from arbitration.
- `tvalid_i`  in  N_PORTS  upstream valid, bit k belongs to port k.
- `tready_o`  out  N_PORTS  upstream ready, bit k belongs to port k.
- `tdata_i`  in  N_PORTS*DATA_W  upstream data; port k occupies bits [k*DATA_W +: DATA_W].
- `tlast_i`  in  N_PORTS  upstream end-of-packet.
- `tvalid_o`  out  1  downstream valid, to `BUFFER.tvalid_i`.
- `tready_i`  in  1  downstream ready, from `BUFFER.tready_o`.
- `tdata_o`  out  DATA_W  downstream data.
- `tlast_o`  out  1  downstream end-of-packet.
- `tid_o`  out  ID_W  index of the granted port.
- `busy_o`  out  1  high while a grant is held (state LOCK).

## Operation
- The FSM has two states. IDLE is the arbitration state. LOCK holds a grant to port `gnt`.
- Request vector: `req = tvalid_i & en_i`.
- IDLE behaviour:
  - If `req` is nonzero, select the first set bit, searching from `(ptr+1) mod N_PORTS` upward with wrap-around.
  - Register the selection into `gnt` and go to LOCK.
  - If `req` is zero, stay in IDLE.
- LOCK behaviour:
  - `tvalid_o = tvalid_i[gnt]`, `tdata_o = tdata_i[gnt]`, `tlast_o = tlast_i[gnt]`.
  - `tready_o[gnt] = tready_i`; all other `tready_o` bits are 0.
  - `tid_o = gnt`, `busy_o = 1`.
- A beat transfers when `tvalid_o & tready_i` are both high.
- If a beat transfers with `tlast_o = 1`: set `ptr <= gnt` and go to IDLE.
- In IDLE, every output is 0: `tready_o`, `tvalid_o`, `tdata_o`, `tlast_o`, `tid_o`, `busy_o`.
- `en_i` is sampled only in IDLE. Clearing `en_i[gnt]` during LOCK has no effect until the packet ends.
- If the granted port drops `tvalid_i` mid-packet, the arbiter stays in LOCK and waits; no timeout.
- A single-beat packet (`tlast` on the first beat) returns to IDLE after one transfer.
- Ports whose `en_i` bit is 0 never receive ready, even if their `tvalid_i` is high.

## Timing
- Reset, sampled at a clock edge with `arstn_i = 0`:
  - state IDLE, `gnt = 0`, `ptr = N_PORTS-1`, so port 0 wins the first arbitration.
  - All outputs are 0 from the cycle after the reset edge.
- Reset asserted mid-packet: abandon the grant at that edge. Any beat presented in that cycle is not acknowledged afterwards; the upstream port must re-send.
- Arbitration latency: the request is sampled in IDLE at edge k, and LOCK is active from edge k.
- The first beat can transfer in the cycle following edge k.
- Between packets there is exactly one IDLE bubble cycle, so peak throughput is L/(L+1) for L-beat packets.
- The downstream ready/valid/data path is combinational, with no added register stage. The registered stage is `BUFFER` itself.
- When several ports request simultaneously, the search order from `ptr+1` decides; there is no fixed priority.

## Test plan
- **Reset priority:** release reset; `tvalid_i=4'b1111`, `en_i=4'b1111`, every port sends a 2-beat packet, `tready_i=1`.
  - Required: `tid_o` sequence 0,1,2,3.
  - Required: one bubble cycle between packets, so 8 beats in 12 cycles.
- **Mask:** `en_i=4'b1010`, all ports valid.
  - Required: only ports 1 and 3 are granted, alternating.
  - Required: `tready_o[0]` and `tready_o[2]` stay 0 throughout.
- **Backpressure:** port 2 sends 3 beats with data 4'h3, 4'h9, 4'hE; `tready_i` pattern 0,1,0,1,1.
  - Required: `tdata_o` holds each value until accepted.
  - Required: all 3 beats transfer; return to IDLE in the cycle after the 4'hE transfer.
- **Lock hold:** port 1 is granted; drop `tvalid_i[1]` for 3 cycles mid-packet while port 0 is valid.
  - Required: `busy_o=1` and `tid_o=1` hold; `tready_o[0]` stays 0.
- **Wrap-around:** after port 3 completes, ports 0 and 3 both request.
  - Required: port 0 is granted next.
- **Reset mid-packet:** assert `arstn_i=0` on beat 2 of a 4-beat packet.
  - Required: next cycle IDLE with all outputs 0.
  - Required: after release, port 0 wins the next arbitration.
